mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one cacheline-wide physical memory port between the instruction
//  cache (read-only) and the data cache (read/write) of the pipelined core.
//  Sits between the two caches and the cacheline adaptor.
//  Serves one transaction at a time. When both caches are pending, grants
//  alternate round-robin. Request fields are latched for the whole transaction.
// PARAMETERS
//  LINE_W  256  cacheline width in bits (rdata/wdata)
//  ADDR_W  32   physical address width
// PORTS
//  clk      in   1       clock; all state updates on rising edge
//  rst      in   1       synchronous, active-high reset
//  i_read   in   1       icache line read request; held until i_resp
//  i_addr   in   ADDR_W  icache line address
//  i_rdata  out  LINE_W  line data to icache; valid while i_resp=1
//  i_resp   out  1       icache transaction done (1-cycle pulse)
//  d_read   in   1       dcache line read request; held until d_resp
//  d_write  in   1       dcache line writeback request; held until d_resp
//  d_addr   in   ADDR_W  dcache line address
//  d_wdata  in   LINE_W  dcache writeback data
//  d_rdata  out  LINE_W  line data to dcache; valid while d_resp=1
//  d_resp   out  1       dcache transaction done (1-cycle pulse)
//  m_read   out  1       memory read strobe; held until m_resp
//  m_write  out  1       memory write strobe; held until m_resp
//  m_addr   out  ADDR_W  memory address (latched copy)
//  m_wdata  out  LINE_W  memory write data (latched copy)
//  m_rdata  in   LINE_W  memory read data; valid with m_resp
//  m_resp   in   1       memory transaction done
// BEHAVIOUR
//  - FSM states: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
//  - Reset values:
//      m_read=m_write=0, i_resp=d_resp=0, m_addr=0, m_wdata=0, last_grant=I.
//  - Arbitration in IDLE, evaluated on the rising edge:
//      d_req = d_read|d_write.
//      Only d_req pending   -> SERVE_D.
//      Only i_read pending  -> SERVE_I.
//      Both pending         -> grant the requester opposite last_grant.
//      Result: D wins the first tie after reset, then ties alternate.
//  - On grant: latch addr (plus d_wdata and op for D) into m_addr/m_wdata/op.
//    Update last_grant to the granted requester.
//  - m_read/m_write are registered outputs, asserted from the cycle after the
//    grant edge. Latency: request at edge N -> strobe visible in cycle N+1.
//  - d_read=d_write=1 together is illegal; the write is performed.
//  - SERVE_x:
//      Hold the strobes and latched fields until m_resp=1.
//      i_resp=m_resp (SERVE_I only), d_resp=m_resp (SERVE_D only),
//      combinational, same cycle as m_resp.
//      i_rdata=d_rdata=m_rdata always (pass-through).
//      On the m_resp edge -> IDLE, strobes drop.
//  - One IDLE cycle always separates transactions (no back-to-back grant).
//  - In IDLE the next cycle, a requester that saw its resp must already be
//    deasserted. A still-high request is treated as a new request.
//  - A requester dropping its request mid-transaction has no effect: the
//    transaction completes and the resp pulse is still issued.
//  - m_resp in IDLE is ignored; no resp is generated.
//  - rst mid-transaction: next edge -> IDLE with all outputs at reset values.
//    A subsequent stray m_resp is ignored.
//  - Never m_read & m_write simultaneously. Never i_resp & d_resp together.
// TESTING
//  1) i_read=1, i_addr=0x0000_1000; memory answers after 5 cycles with
//     m_rdata=pattern A -> m_read high at cycles 1-5, m_addr=0x1000,
//     i_resp single pulse with i_rdata=A, d_resp stays 0.
//  2) d_write=1, d_addr=0x8000_0040, d_wdata=B -> m_write=1, m_addr and
//     m_wdata stable until m_resp, one d_resp pulse, m_read=0 throughout.
//  3) After reset, i_read and d_read raised on the same cycle and held
//     re-requesting -> grants run D, I, D, I, with one IDLE cycle
//     between each grant.
//  4) d_read held and i_read held continuously, 10 transactions ->
//     exactly 5 i_resp and 5 d_resp, strictly alternating.
//  5) rst asserted 2 cycles into SERVE_D, then m_resp pulsed -> state IDLE,
//     m_read=0, d_resp never asserted.
//  6) i_addr changed mid-transaction -> m_addr keeps the latched value
//     until m_resp.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-client cacheline memory arbiter: icache (read-only) and dcache (read/write)
// share one memory port, one transaction at a time, round-robin on ties.
module mem_arbiter #(
    parameter int unsigned LINE_W = 256,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // icache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // dcache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // memory side
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp
);

    typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_t;

    state_t state;
    logic   last_was_d;   // 0: icache granted last, 1: dcache granted last
    logic   d_req;
    logic   grant_d;

    assign d_req   = d_read | d_write;
    // D wins when alone, or on a tie when I was granted last
    assign grant_d = d_req & (~i_read | ~last_was_d);

    // Arbitration FSM with registered strobes and latched request fields
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            last_was_d <= 1'b0;
            m_read     <= 1'b0;
            m_write    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (grant_d) begin
                        state      <= StServeD;
                        last_was_d <= 1'b1;
                        m_addr     <= d_addr;
                        m_wdata    <= d_wdata;
                        // Read+write together is illegal; the write takes priority
                        m_write    <= d_write;
                        m_read     <= ~d_write;
                    end else if (i_read) begin
                        state      <= StServeI;
                        last_was_d <= 1'b0;
                        m_addr     <= i_addr;
                        m_read     <= 1'b1;
                        m_write    <= 1'b0;
                    end
                end
                StServeI, StServeD: begin
                    if (m_resp) begin
                        state   <= StIdle;
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Responses follow m_resp combinationally, routed by the current owner
    always_comb begin
        i_resp = (state == StServeI) & m_resp;
        d_resp = (state == StServeD) & m_resp;
    end

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected transactions,
// a monitor pops and checks them on every response pulse.
module tb_mem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    typedef logic [LW-1:0] w_t;

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr, m_addr;
    logic [LW-1:0] i_rdata, d_rdata, d_wdata, m_wdata, m_rdata;
    logic          i_resp, d_resp, m_read, m_write, m_resp;
    logic          mem_resp, stray_resp;

    assign m_resp = mem_resp | stray_resp;

    always #5 clk = ~clk;

    mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_read  (i_read),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_resp  (i_resp),
        .d_read  (d_read),
        .d_write (d_write),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_resp  (d_resp),
        .m_read  (m_read),
        .m_write (m_write),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_resp  (m_resp)
    );

    int   checks = 0;
    int   errors = 0;
    int   n_i = 0;
    int   n_d = 0;
    exp_t q[$];

    function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
        return {8{a ^ 32'hA5A5_0000}};
    endfunction

    task automatic check(input string name, input w_t act, input w_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Memory model: answers a held strobe in its lat-th cycle
    bit mem_en = 1'b1;
    int lat = 5;
    initial begin
        int cnt;
        cnt = 0;
        mem_resp = 1'b0;
        m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!mem_en) begin
                cnt = 0;
            end else if (mem_resp) begin
                mem_resp = 1'b0;
                m_rdata = '0;
                cnt = 0;
            end else if (m_read || m_write) begin
                cnt++;
                if (cnt >= lat) begin
                    mem_resp = 1'b1;
                    m_rdata = m_read ? pat(m_addr) : '0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: protocol invariants every cycle, scoreboard pop on each resp
    initial begin
        bit   prev_resp;
        exp_t e;
        prev_resp = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("strobe_exclusive", w_t'(m_read & m_write), w_t'(0));
                check("resp_exclusive", w_t'(i_resp & d_resp), w_t'(0));
                if (prev_resp) check("idle_gap", w_t'(m_read | m_write), w_t'(0));
                prev_resp = i_resp | d_resp;
                if (i_resp || d_resp) begin
                    if (i_resp) n_i++;
                    if (d_resp) n_d++;
                    if (q.size() == 0) begin
                        check("unexpected_resp", w_t'(1), w_t'(0));
                    end else begin
                        e = q.pop_front();
                        check("resp_src_d", w_t'(d_resp), w_t'(e.is_d));
                        check("m_addr", w_t'(m_addr), w_t'(e.addr));
                        check("op_write", w_t'(m_write), w_t'(e.wr));
                        check("op_read", w_t'(m_read), w_t'(!e.wr));
                        if (e.wr) check("m_wdata", m_wdata, e.wdata);
                        else check("rdata", e.is_d ? d_rdata : i_rdata, pat(e.addr));
                    end
                end
            end else begin
                prev_resp = 1'b0;
            end
        end
    end

    task automatic push(input bit is_d, input bit wr, input logic [AW-1:0] a,
                        input logic [LW-1:0] wd);
        exp_t e;
        e.is_d = is_d;
        e.wr = wr;
        e.addr = a;
        e.wdata = wd;
        q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for the next resp pulse, counting strobe cycles on the way
    task automatic wait_resp(input int budget, output int rd, output int wr, output bit ok);
        rd = 0;
        wr = 0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (m_read) rd++;
            if (m_write) wr++;
            if (i_resp || d_resp) begin
                ok = 1'b1;
                break;
            end
        end
        check("resp_timeout", w_t'(ok), w_t'(1));
    endtask

    localparam logic [LW-1:0] PAT_B = {4{64'hDEAD_BEEF_0123_4567}};

    initial begin
        int rd, wr, ni0, nd0;
        bit ok;
        rst = 1'b1;
        i_read = 1'b0;
        d_read = 1'b0;
        d_write = 1'b0;
        i_addr = '0;
        d_addr = '0;
        d_wdata = '0;
        stray_resp = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_m_read", w_t'(m_read), w_t'(0));
        check("rst_m_write", w_t'(m_write), w_t'(0));
        check("rst_resp", w_t'(i_resp | d_resp), w_t'(0));
        check("rst_m_addr", w_t'(m_addr), w_t'(0));
        check("rst_m_wdata", m_wdata, w_t'(0));

        // icache read, 5-cycle memory
        i_addr = 32'h0000_1000;
        i_read = 1'b1;
        push(1'b0, 1'b0, 32'h0000_1000, '0);
        wait_resp(50, rd, wr, ok);
        i_read = 1'b0;
        check("t1_read_cycles", w_t'(rd), w_t'(5));
        check("t1_write_cycles", w_t'(wr), w_t'(0));
        @(negedge clk);

        // dcache writeback
        d_addr = 32'h8000_0040;
        d_wdata = PAT_B;
        d_write = 1'b1;
        push(1'b1, 1'b1, 32'h8000_0040, PAT_B);
        wait_resp(50, rd, wr, ok);
        d_write = 1'b0;
        check("t2_read_cycles", w_t'(rd), w_t'(0));
        check("t2_write_cycles", w_t'(wr), w_t'(5));
        @(negedge clk);

        // icache address changes mid-transaction
        i_addr = 32'h0000_2000;
        i_read = 1'b1;
        push(1'b0, 1'b0, 32'h0000_2000, '0);
        repeat (2) @(negedge clk);
        i_addr = 32'h0000_3000;
        @(negedge clk);
        check("t6_addr_held", w_t'(m_addr), w_t'(32'h0000_2000));
        wait_resp(50, rd, wr, ok);
        i_read = 1'b0;
        @(negedge clk);

        // Contending requesters after reset: D first, then strict alternation
        do_reset();
        ni0 = n_i;
        nd0 = n_d;
        i_addr = 32'h0000_4000;
        d_addr = 32'h0000_5000;
        for (int k = 0; k < 5; k++) begin
            push(1'b1, 1'b0, 32'h0000_5000, PAT_B);
            push(1'b0, 1'b0, 32'h0000_4000, '0);
        end
        i_read = 1'b1;
        d_read = 1'b1;
        for (int k = 0; k < 10; k++) wait_resp(50, rd, wr, ok);
        i_read = 1'b0;
        d_read = 1'b0;
        @(negedge clk);
        check("t4_i_count", w_t'(n_i - ni0), w_t'(5));
        check("t4_d_count", w_t'(n_d - nd0), w_t'(5));
        check("t4_queue_empty", w_t'(q.size()), w_t'(0));

        // Reset two cycles into a dcache read, then a stray m_resp
        mem_en = 1'b0;
        d_addr = 32'h0000_6000;
        d_read = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_serving", w_t'(m_read), w_t'(1));
        rst = 1'b1;
        d_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("t5_m_read", w_t'(m_read), w_t'(0));
        check("t5_m_addr", w_t'(m_addr), w_t'(0));
        check("t5_m_wdata", m_wdata, w_t'(0));
        stray_resp = 1'b1;
        @(negedge clk);
        check("t5_d_resp", w_t'(d_resp), w_t'(0));
        check("t5_i_resp", w_t'(i_resp), w_t'(0));
        stray_resp = 1'b0;
        mem_en = 1'b1;
        @(negedge clk);
        check("t5_idle", w_t'(m_read | m_write), w_t'(0));

        // Normal service resumes after the aborted transaction
        d_addr = 32'h0000_7000;
        d_read = 1'b1;
        push(1'b1, 1'b0, 32'h0000_7000, '0);
        wait_resp(50, rd, wr, ok);
        d_read = 1'b0;
        check("t5_resume_reads", w_t'(rd), w_t'(5));
        @(negedge clk);
        check("final_queue_empty", w_t'(q.size()), w_t'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog");
    end

endmodule
